// File: rtl/pzc_tail_gen_if.sv
// Sample-stream bundle for the pole-zero tail generator: an input sample
// with its valid strobe, and the shaped output with its valid strobe.
interface pzc_tail_gen_if #(
   parameter int NBITS_IN  = 12,
   parameter int NBITS_OUT = 28
);
   logic                        in_valid;
   logic signed [NBITS_IN-1:0]  in;
   logic signed [NBITS_OUT-1:0] io_out;
   logic                        out_valid;

   // master sources samples and consumes the shaped result; slave is the generator
   modport master (
      output in_valid,
      output in,
      input  io_out,
      input  out_valid
   );

   modport slave (
      input  in_valid,
      input  in,
      output io_out,
      output out_valid
   );
endinterface

// File: rtl/pzc_tail_gen.sv
// Exponential tail generator: a leaky accumulator emulating alpha = M/(M+1)
// decay, with run/drain sequencing, output clamping and an activity mask.
module pzc_tail_gen #(
   parameter int NBITS_IN    = 12,
   parameter int NBITS_OUT   = 28,
   parameter int M_FACTOR    = 454,
   parameter int FRAC_BITS   = 16,
   parameter int SETTLE_THR  = 512,
   parameter int DRAIN_MAX   = 4095,
   parameter int HOLD_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                sat_clr,
   pzc_tail_gen_if.slave       bus,
   output logic                bt_mask_out,
   output logic                busy,
   output logic                sat_flag,
   output logic [15:0]         sat_cnt
);

   localparam int RECIP = ((2 ** FRAC_BITS) + ((M_FACTOR + 1) / 2)) / (M_FACTOR + 1);
   localparam int SW    = NBITS_OUT + 2;
   localparam int PW    = NBITS_OUT + FRAC_BITS + 2;
   localparam int DW    = $clog2(DRAIN_MAX + 1);
   localparam int HW    = $clog2(HOLD_CYCLES + 1);

   localparam logic signed [PW-1:0] RECIP_W = PW'(RECIP);
   localparam logic signed [SW-1:0] ACC_MAX = {3'b000, {(NBITS_OUT-1){1'b1}}};
   localparam logic signed [SW-1:0] ACC_MIN = {3'b111, {(NBITS_OUT-1){1'b0}}};
   localparam logic signed [NBITS_OUT:0] THR_W = (NBITS_OUT+1)'(SETTLE_THR);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);
   localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                      state_reg, state_next;
   logic signed [NBITS_OUT-1:0] acc_reg, acc_next;
   logic signed [NBITS_IN-1:0]  x_reg;
   logic                        v1_reg;
   logic                        out_valid_reg, out_valid_next;
   logic [HW-1:0]               hold_reg, hold_next;
   logic [DW-1:0]               drain_reg, drain_next;
   logic                        sat_flag_reg, sat_flag_next;
   logic [15:0]                 sat_cnt_reg, sat_cnt_next;

   // datapath for one decay step
   logic signed [NBITS_IN-1:0]  x_sel;
   logic signed [PW-1:0]        acc_wide;
   logic signed [PW-1:0]        prod_w;
   logic signed [PW-1:0]        decay_w;
   logic signed [SW-1:0]        sum_w;
   logic signed [NBITS_OUT-1:0] acc_clamped;
   logic                        clamp_hit;
   logic                        upd;
   logic signed [NBITS_OUT:0]   acc_ext;
   logic signed [NBITS_OUT:0]   acc_mag;
   logic                        settled;

   // drain steps feed zero; run steps feed the registered sample
   assign x_sel    = (state_reg == RUN) ? x_reg : '0;
   assign acc_wide = PW'(acc_reg);
   assign prod_w   = acc_wide * RECIP_W;
   assign decay_w  = prod_w >>> FRAC_BITS;
   assign sum_w    = SW'(acc_reg) - SW'(decay_w) + SW'(x_sel);

   always_comb begin
      acc_clamped = sum_w[NBITS_OUT-1:0];
      clamp_hit   = 1'b0;
      if (sum_w > ACC_MAX) begin
         acc_clamped = ACC_MAX[NBITS_OUT-1:0];
         clamp_hit   = 1'b1;
      end else if (sum_w < ACC_MIN) begin
         acc_clamped = ACC_MIN[NBITS_OUT-1:0];
         clamp_hit   = 1'b1;
      end
   end

   // one extra bit so the most negative accumulator value has a magnitude
   assign acc_ext = (NBITS_OUT+1)'(acc_reg);
   assign acc_mag = (acc_ext < 0) ? -acc_ext : acc_ext;
   assign settled = (acc_mag <= THR_W);

   always_comb begin
      state_next     = state_reg;
      acc_next       = acc_reg;
      out_valid_next = 1'b0;
      hold_next      = (hold_reg != '0) ? hold_reg - HW'(1) : '0;
      drain_next     = drain_reg;
      upd            = 1'b0;
      case (state_reg)
         IDLE: begin
            acc_next   = '0;
            hold_next  = '0;
            drain_next = '0;
            if (en) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (v1_reg) begin
               upd            = 1'b1;
               acc_next       = acc_clamped;
               out_valid_next = 1'b1;
               if (x_reg != '0) begin
                  hold_next = HOLD_LOAD;
               end
            end
            if (!en) begin
               state_next = DRAIN;
               drain_next = '0;
            end
         end
         DRAIN: begin
            if (en) begin
               state_next = RUN;
            end else if (settled || (drain_reg == DRAIN_LAST)) begin
               state_next = IDLE;
               acc_next   = '0;
               hold_next  = '0;
            end else begin
               upd            = 1'b1;
               acc_next       = acc_clamped;
               out_valid_next = 1'b1;
               drain_next     = drain_reg + DW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            acc_next   = '0;
         end
      endcase
   end

   // a clamp in the same cycle as a clear wins and counts as the first event
   always_comb begin
      sat_flag_next = sat_flag_reg;
      sat_cnt_next  = sat_cnt_reg;
      if (upd && clamp_hit) begin
         sat_flag_next = 1'b1;
         if (sat_clr) begin
            sat_cnt_next = 16'd1;
         end else if (sat_cnt_reg != 16'hFFFF) begin
            sat_cnt_next = sat_cnt_reg + 16'd1;
         end
      end else if (sat_clr) begin
         sat_flag_next = 1'b0;
         sat_cnt_next  = 16'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_reg  <= '0;
         v1_reg <= 1'b0;
      end else begin
         x_reg  <= bus.in;
         v1_reg <= bus.in_valid & en;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         acc_reg       <= '0;
         out_valid_reg <= 1'b0;
         hold_reg      <= '0;
         drain_reg     <= '0;
         sat_flag_reg  <= 1'b0;
         sat_cnt_reg   <= 16'd0;
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         out_valid_reg <= out_valid_next;
         hold_reg      <= hold_next;
         drain_reg     <= drain_next;
         sat_flag_reg  <= sat_flag_next;
         sat_cnt_reg   <= sat_cnt_next;
      end
   end

   assign bus.io_out    = acc_reg;
   assign bus.out_valid = out_valid_reg;
   assign bt_mask_out   = (hold_reg != '0) && (state_reg != IDLE);
   assign busy          = (state_reg != IDLE);
   assign sat_flag      = sat_flag_reg;
   assign sat_cnt       = sat_cnt_reg;

endmodule

// File: tb/tb_pzc_tail_gen.sv
// Directed bench for pzc_tail_gen: a default instance for impulse, decay,
// drain, mask and reset, and a 14-bit instance for clamping and drain timeout.
module tb_pzc_tail_gen;

   logic        clk;
   logic        rst;
   logic        en_a, sat_clr_a, mask_a, busy_a, flag_a;
   logic [15:0] cnt_a;
   logic        en_b, sat_clr_b, mask_b, busy_b, flag_b;
   logic [15:0] cnt_b;

   int errors = 0;
   int checks = 0;
   int exp_a;
   int x_pipe;
   int exp_b;
   int prev;
   bit done;

   pzc_tail_gen_if #(.NBITS_IN(12), .NBITS_OUT(28)) bus_a ();
   pzc_tail_gen_if #(.NBITS_IN(12), .NBITS_OUT(14)) bus_b ();

   pzc_tail_gen dut_a (
      .clk(clk), .rst(rst), .en(en_a), .sat_clr(sat_clr_a), .bus(bus_a),
      .bt_mask_out(mask_a), .busy(busy_a), .sat_flag(flag_a), .sat_cnt(cnt_a)
   );

   pzc_tail_gen #(.NBITS_OUT(14), .DRAIN_MAX(10)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .sat_clr(sat_clr_b), .bus(bus_b),
      .bt_mask_out(mask_b), .busy(busy_b), .sat_flag(flag_b), .sat_cnt(cnt_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // decay step at the default coefficient 144 / 2^16, floor shift
   function automatic int dec(input int a);
      longint p;
      p = longint'(a) * 64'sd144;
      return a - int'(p >>> 16);
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // advance instance A one edge while it runs with a valid sample every cycle
   task automatic run_tick();
      exp_a  = dec(exp_a) + x_pipe;
      x_pipe = bus_a.in_valid ? int'(bus_a.in) : 0;
      tick();
   endtask

   initial begin
      rst = 1'b0;
      en_a = 1'b0; sat_clr_a = 1'b0; bus_a.in_valid = 1'b0; bus_a.in = '0;
      en_b = 1'b0; sat_clr_b = 1'b0; bus_b.in_valid = 1'b0; bus_b.in = '0;
      #12;
      chk("rst_io", bus_a.io_out, 0);
      chk("rst_ov", bus_a.out_valid, 0);
      chk("rst_mask", mask_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_flag", flag_a, 0);
      chk("rst_cnt", cnt_a, 0);
      chk("rst_io_b", bus_b.io_out, 0);
      rst = 1'b1;
      tick();
      chk("idle_no_en", busy_a, 0);

      // impulse of 1000 followed by valid zeros
      exp_a = 0; x_pipe = 0;
      en_a = 1'b1; bus_a.in_valid = 1'b1; bus_a.in = 12'sd1000;
      run_tick();
      chk("imp_lat_ov", bus_a.out_valid, 0);
      chk("imp_busy", busy_a, 1);
      bus_a.in = '0;
      run_tick();
      chk("imp_first", bus_a.io_out, 1000);
      chk("imp_ov", bus_a.out_valid, 1);
      chk("imp_mask", mask_a, 1);
      run_tick();
      chk("imp_second", bus_a.io_out, 998);
      run_tick();
      chk("imp_third", bus_a.io_out, 996);
      for (int i = 0; i < 13; i++) begin
         run_tick();
         chk("imp_decay", bus_a.io_out, exp_a);
         chk("mask_hold", mask_a, 1);
      end
      run_tick();
      chk("mask_expire", mask_a, 0);

      // drain to the settle threshold
      en_a = 1'b0; bus_a.in_valid = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 2000 && !done; i++) begin
         prev = exp_a;
         tick();
         if (prev <= 512) begin
            chk("drain_io", bus_a.io_out, 0);
            chk("drain_ov", bus_a.out_valid, 0);
            chk("drain_busy", busy_a, 0);
            done = 1'b1;
         end else begin
            exp_a = dec(prev);
            chk("drain_val", bus_a.io_out, exp_a);
            chk("drain_ov", bus_a.out_valid, 1);
         end
      end
      if (!done) chk("drain_timeout", 0, 1);

      // single negative sample decays toward zero with floor shift
      exp_a = 0; x_pipe = 0;
      en_a = 1'b1; bus_a.in_valid = 1'b1; bus_a.in = -12'sd100;
      run_tick();
      bus_a.in = '0;
      run_tick();
      chk("neg_first", bus_a.io_out, -100);
      chk("neg_mask", mask_a, 1);
      run_tick();
      chk("neg_second", bus_a.io_out, -99);
      run_tick();
      chk("neg_third", bus_a.io_out, -98);
      for (int i = 0; i < 13; i++) run_tick();
      chk("neg_mask_hi", mask_a, 1);
      run_tick();
      chk("neg_mask_lo", mask_a, 0);

      // a second nonzero sample mid-hold restarts the hold
      bus_a.in = 12'sd50;
      run_tick();
      bus_a.in = '0;
      run_tick();
      chk("rs_val", bus_a.io_out, exp_a);
      chk("rs_mask", mask_a, 1);
      for (int i = 0; i < 7; i++) run_tick();
      bus_a.in = -12'sd30;
      run_tick();
      chk("rs_mask_mid", mask_a, 1);
      bus_a.in = '0;
      run_tick();
      chk("rs_val2", bus_a.io_out, exp_a);
      for (int i = 0; i < 15; i++) begin
         run_tick();
         chk("rs_hold", mask_a, 1);
      end
      run_tick();
      chk("rs_expire", mask_a, 0);

      // asynchronous reset in the middle of RUN
      bus_a.in = 12'sd2047;
      run_tick(); run_tick(); run_tick();
      chk("pre_rst_val", bus_a.io_out, exp_a);
      chk("pre_rst_nz", bus_a.io_out != 0, 1);
      bus_a.in = '0;
      #3;
      rst = 1'b0;
      #1;
      chk("arst_io", bus_a.io_out, 0);
      chk("arst_ov", bus_a.out_valid, 0);
      chk("arst_busy", busy_a, 0);
      chk("arst_mask", mask_a, 0);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_io", bus_a.io_out, 0);
      end
      en_a = 1'b0; bus_a.in_valid = 1'b0;

      // 14-bit instance: clamping and the saturation counter
      en_b = 1'b1; bus_b.in_valid = 1'b1; bus_b.in = 12'sd2047;
      tick();
      tick(); chk("sat_e2", bus_b.io_out, 2047);
      tick(); chk("sat_e3", bus_b.io_out, 4090);
      tick(); chk("sat_e4", bus_b.io_out, 6129);
      tick(); chk("sat_e5", bus_b.io_out, 8163);
      chk("sat_e5_flag", flag_b, 0);
      tick(); chk("sat_e6", bus_b.io_out, 8191);
      chk("sat_e6_flag", flag_b, 1);
      chk("sat_e6_cnt", cnt_b, 1);
      tick(); chk("sat_e7_cnt", cnt_b, 2);
      sat_clr_b = 1'b1;
      tick();
      chk("sat_clr_flag", flag_b, 1);
      chk("sat_clr_cnt", cnt_b, 1);
      chk("sat_clr_io", bus_b.io_out, 8191);
      sat_clr_b = 1'b0; bus_b.in_valid = 1'b0;
      tick(); chk("sat_e9_cnt", cnt_b, 2);
      tick();
      chk("hold_ov", bus_b.out_valid, 0);
      chk("hold_io", bus_b.io_out, 8191);
      chk("hold_cnt", cnt_b, 2);
      sat_clr_b = 1'b1;
      tick();
      chk("clr_flag", flag_b, 0);
      chk("clr_cnt", cnt_b, 0);
      sat_clr_b = 1'b0;

      // drain timeout after exactly ten drain cycles
      en_b = 1'b0;
      tick();
      chk("dmax_entry_busy", busy_b, 1);
      chk("dmax_entry_ov", bus_b.out_valid, 0);
      exp_b = 8191;
      for (int i = 0; i < 9; i++) begin
         tick();
         exp_b = dec(exp_b);
         chk("dmax_val", bus_b.io_out, exp_b);
         chk("dmax_ov", bus_b.out_valid, 1);
         chk("dmax_busy", busy_b, 1);
      end
      tick();
      chk("dmax_end_busy", busy_b, 0);
      chk("dmax_end_io", bus_b.io_out, 0);
      chk("dmax_end_ov", bus_b.out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
